// File: rtl/fatori_mon_imd_val_reg.sv
// fatori_mon_imd_val_reg: M-of-N voted storage for two 32-bit intermediate values with background scrub and fault injection; ports: clk_i/rst_i, imd_val_d_i/we_i in, imd_val_q_o out, scrub_en_i, inj_* fault port, min/maj error flags, sticky maj flag, scrub_occurred_o pulse
module fatori_mon_imd_val_reg #(
  parameter int N            = 3,
  parameter int M            = 2,
  parameter int SCRUB_PERIOD = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0][31:0] imd_val_d_i,
  input  logic [1:0]       imd_val_we_i,
  output logic [1:0][31:0] imd_val_q_o,
  input  logic             scrub_en_i,
  input  logic             inj_en_i,
  input  logic [2:0]       inj_rep_i,
  input  logic             inj_word_i,
  input  logic [31:0]      inj_mask_i,
  output logic             min_err_o,
  output logic             maj_err_o,
  output logic             maj_err_sticky_o,
  output logic             scrub_occurred_o
);
  localparam int CW = $clog2(SCRUB_PERIOD);
  typedef enum logic [1:0] {IDLE, CHECK, REPAIR} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic wp, wp_n;
  logic [N-1:0][1:0][31:0] rep;
  logic [3:0] ones;
  logic [1:0] maj_w, diff_w;
  logic repair;
  always_comb begin
    imd_val_q_o = '0;
    maj_w = '0;
    diff_w = '0;
    ones = '0;
    for (int w = 0; w < 2; w++) begin
      for (int b = 0; b < 32; b++) begin
        ones = '0;
        for (int r = 0; r < N; r++) ones = ones + 4'(rep[r][w][b]);
        imd_val_q_o[w][b] = ones >= 4'(M);
        maj_w[w] = maj_w[w] | ((ones < 4'(M)) && (4'(N) - ones < 4'(M)));
      end
      for (int r = 0; r < N; r++) diff_w[w] = diff_w[w] | (|(rep[r][w] ^ imd_val_q_o[w]));
    end
  end
  assign min_err_o = |diff_w;
  assign maj_err_o = |maj_w;
  // a same-edge functional write to the scrubbed word wins and abandons the repair
  assign repair = (state == REPAIR) && !imd_val_we_i[wp];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    wp_n = wp;
    case (state)
      IDLE: if (scrub_en_i) begin
        cnt_n = (cnt == CW'(SCRUB_PERIOD - 1)) ? '0 : cnt + 1'b1;
        state_n = (cnt == CW'(SCRUB_PERIOD - 1)) ? CHECK : IDLE;
      end
      CHECK: begin
        state_n = (diff_w[wp] && !maj_w[wp]) ? REPAIR : IDLE;
        wp_n = (diff_w[wp] && !maj_w[wp]) ? wp : ~wp;
      end
      REPAIR: begin
        state_n = IDLE;
        wp_n = ~wp;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      wp <= 1'b0;
      rep <= '0;
      maj_err_sticky_o <= 1'b0;
      scrub_occurred_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      wp <= wp_n;
      maj_err_sticky_o <= maj_err_sticky_o | maj_err_o;
      scrub_occurred_o <= repair;
      for (int r = 0; r < N; r++) begin
        for (int w = 0; w < 2; w++) begin
          if (imd_val_we_i[w]) rep[r][w] <= imd_val_d_i[w];
          else if (repair && wp == 1'(w)) rep[r][w] <= imd_val_q_o[w];
          else if (inj_en_i && inj_rep_i == 3'(r) && inj_word_i == 1'(w)) rep[r][w] <= rep[r][w] ^ inj_mask_i;
        end
      end
    end
  end
endmodule

// File: tb/tb_fatori_mon_imd_val_reg.sv
// tb_fatori_mon_imd_val_reg: directed checks of voting, priority, scrub timing and reset on N=3/M=2 and N=3/M=3 instances
module tb_fatori_mon_imd_val_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][31:0] d = '0;
  logic [1:0] we = '0;
  logic scrub_en = 1'b0;
  logic inj_en = 1'b0;
  logic [2:0] inj_rep = '0;
  logic inj_word = 1'b0;
  logic [31:0] inj_mask = '0;
  logic [1:0][31:0] q_a, q_b;
  logic mn_a, mj_a, st_a, p_a, mn_b, mj_b, st_b, p_b;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fatori_mon_imd_val_reg #(.N(3), .M(2), .SCRUB_PERIOD(16)) u_a (
    .clk_i(clk), .rst_i(rst), .imd_val_d_i(d), .imd_val_we_i(we), .imd_val_q_o(q_a),
    .scrub_en_i(scrub_en), .inj_en_i(inj_en), .inj_rep_i(inj_rep), .inj_word_i(inj_word),
    .inj_mask_i(inj_mask), .min_err_o(mn_a), .maj_err_o(mj_a), .maj_err_sticky_o(st_a),
    .scrub_occurred_o(p_a));
  fatori_mon_imd_val_reg #(.N(3), .M(3), .SCRUB_PERIOD(16)) u_b (
    .clk_i(clk), .rst_i(rst), .imd_val_d_i(d), .imd_val_we_i(we), .imd_val_q_o(q_b),
    .scrub_en_i(scrub_en), .inj_en_i(inj_en), .inj_rep_i(inj_rep), .inj_word_i(inj_word),
    .inj_mask_i(inj_mask), .min_err_o(mn_b), .maj_err_o(mj_b), .maj_err_sticky_o(st_b),
    .scrub_occurred_o(p_b));
  typedef struct {
    logic [1:0]  we;
    logic [31:0] d0, d1;
    logic        inj;
    logic [2:0]  rep;
    logic        word;
    logic [31:0] mask;
    logic [31:0] q0, q1;
    logic        mn, mj, mj_b;
  } vec_t;
  vec_t v[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    scrub_en = 1'b0;
    we = '0;
    inj_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic wr(input logic [1:0] w, input logic [31:0] x0, input logic [31:0] x1);
    we = w;
    d[0] = x0;
    d[1] = x1;
    tick();
    we = '0;
  endtask
  task automatic inj(input logic [2:0] r, input logic wd, input logic [31:0] m);
    inj_en = 1'b1;
    inj_rep = r;
    inj_word = wd;
    inj_mask = m;
    tick();
    inj_en = 1'b0;
  endtask
  // leaves u_a in its REPAIR cycle for word 0 (16 IDLE cycles, CHECK, then REPAIR)
  task automatic to_repair();
    do_reset();
    wr(2'b11, 32'hDEADBEEF, 32'h12345678);
    inj(3'd1, 1'b0, 32'h1);
    scrub_en = 1'b1;
    repeat (17) tick();
    chk("pre_repair_pulse", 32'(p_a), 32'd0);
  endtask
  initial begin
    int n;
    v[0] = '{2'b11, 32'hDEADBEEF, 32'h12345678, 1'b0, 3'd0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h12345678, 1'b0, 1'b0, 1'b0};
    v[1] = '{2'b00, 32'h0, 32'h0, 1'b1, 3'd1, 1'b0, 32'h1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0, 1'b1};
    v[2] = '{2'b00, 32'h0, 32'h0, 1'b1, 3'd2, 1'b0, 32'h1, 32'hDEADBEEE, 32'h12345678, 1'b1, 1'b0, 1'b1};
    v[3] = '{2'b00, 32'h0, 32'h0, 1'b1, 3'd3, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEE, 32'h12345678, 1'b1, 1'b0, 1'b1};
    v[4] = '{2'b01, 32'h0, 32'h0, 1'b1, 3'd0, 1'b0, 32'hFF, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0};
    v[5] = '{2'b00, 32'h0, 32'h0, 1'b1, 3'd0, 1'b1, 32'h0000FFFF, 32'h0, 32'h12345678, 1'b1, 1'b0, 1'b1};
    v[6] = '{2'b10, 32'h0, 32'hCAFEF00D, 1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    v[7] = '{2'b00, 32'h0, 32'h0, 1'b1, 3'd7, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0};
    do_reset();
    chk("rst_q0", q_a[0], 32'h0);
    chk("rst_q1", q_a[1], 32'h0);
    chk("rst_flags", {28'h0, mn_a, mj_a, st_a, p_a}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      we = v[i].we;
      d[0] = v[i].d0;
      d[1] = v[i].d1;
      inj_en = v[i].inj;
      inj_rep = v[i].rep;
      inj_word = v[i].word;
      inj_mask = v[i].mask;
      tick();
      we = '0;
      inj_en = 1'b0;
      chk($sformatf("v%0d_q0", i), q_a[0], v[i].q0);
      chk($sformatf("v%0d_q1", i), q_a[1], v[i].q1);
      chk($sformatf("v%0d_min", i), 32'(mn_a), 32'(v[i].mn));
      chk($sformatf("v%0d_maj", i), 32'(mj_a), 32'(v[i].mj));
      chk($sformatf("v%0d_maj_m3", i), 32'(mj_b), 32'(v[i].mj_b));
    end
    to_repair();
    tick();
    chk("scrub_pulse", 32'(p_a), 32'd1);
    chk("scrub_q0", q_a[0], 32'hDEADBEEF);
    chk("scrub_min", 32'(mn_a), 32'd0);
    tick();
    chk("scrub_pulse_end", 32'(p_a), 32'd0);
    n = 0;
    repeat (24) begin
      tick();
      if (p_a) n++;
    end
    chk("scrub_no_extra", n, 0);
    do_reset();
    wr(2'b10, 32'h0, 32'h0F0F0F0F);
    inj(3'd0, 1'b1, 32'h80000000);
    chk("m3_maj", 32'(mj_b), 32'd1);
    tick();
    chk("m3_sticky", 32'(st_b), 32'd1);
    scrub_en = 1'b1;
    n = 0;
    repeat (40) begin
      tick();
      if (p_b) n++;
    end
    scrub_en = 1'b0;
    chk("m3_no_repair", n, 0);
    chk("m3_maj_held", 32'(mj_b), 32'd1);
    wr(2'b10, 32'h0, 32'h0F0F0F0F);
    chk("m3_rewrite_maj", 32'(mj_b), 32'd0);
    chk("m3_rewrite_q1", q_b[1], 32'h0F0F0F0F);
    tick();
    chk("m3_sticky_held", 32'(st_b), 32'd1);
    to_repair();
    we = 2'b01;
    d[0] = 32'h55AA55AA;
    tick();
    we = '0;
    chk("abandon_q0", q_a[0], 32'h55AA55AA);
    chk("abandon_min", 32'(mn_a), 32'd0);
    chk("abandon_pulse", 32'(p_a), 32'd0);
    tick();
    chk("abandon_pulse2", 32'(p_a), 32'd0);
    to_repair();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    scrub_en = 1'b0;
    chk("rst_rep_q0", q_a[0], 32'h0);
    chk("rst_rep_q1", q_a[1], 32'h0);
    chk("rst_rep_pulse", 32'(p_a), 32'd0);
    chk("rst_rep_sticky", {30'h0, st_a, st_b}, 32'h0);
    tick();
    chk("rst_rep_pulse2", 32'(p_a), 32'd0);
    inj(3'd2, 1'b0, 32'h4);
    chk("rst_rep_min", 32'(mn_a), 32'd1);
    scrub_en = 1'b1;
    repeat (17) tick();
    chk("rst_idle_nopulse", 32'(p_a), 32'd0);
    tick();
    chk("rst_idle_pulse", 32'(p_a), 32'd1);
    do_reset();
    inj(3'd0, 1'b1, 32'h10);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (p_a || !mn_a) n++;
    end
    chk("noscrub_hold", n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
